// File: rtl/game_flow_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl_if
//
// Purpose: bundles every non-clock signal between the arena game blocks
// (player, enemies, bullets, renderer) and the game-flow controller.
//
// Signals (named from the controller's point of view):
//   i_select         debounced select level
//   i_pause          debounced pause level
//   i_player_hit     bad-bullet hit pulse on the player
//   i_player_shield  player shield active
//   i_enemy_hit      good-bullet hit pulse, one bit per enemy
//   i_enemy_shield   shield active, one bit per enemy
//   o_state          START=0, PLAY=1, PAUSE=2, WIN=3, LOSE=4
//   o_is_gaming      high while in PLAY
//   o_player_hp      player hit points
//   o_enemy_hp       enemy i hit points at [i*HP_W +: HP_W]
//   o_enemy_alive    bit i set while enemy i has HP left
//   o_player_iframe  player invulnerability window active
//   o_ai_tick        one-cycle pacing pulse for the enemy random movers
//   o_round_time     AI ticks elapsed this round, saturating
//
// Modports:
//   slave  - the controller (consumes i_*, produces o_*)
//   master - the surrounding game logic / testbench
// ---------------------------------------------------------------------------
interface game_flow_ctrl_if #(
    parameter int NUM_ENEMIES = 2,
    parameter int HP_W        = 3
);
    logic                        i_select;
    logic                        i_pause;
    logic                        i_player_hit;
    logic                        i_player_shield;
    logic [NUM_ENEMIES-1:0]      i_enemy_hit;
    logic [NUM_ENEMIES-1:0]      i_enemy_shield;

    logic [2:0]                  o_state;
    logic                        o_is_gaming;
    logic [HP_W-1:0]             o_player_hp;
    logic [NUM_ENEMIES*HP_W-1:0] o_enemy_hp;
    logic [NUM_ENEMIES-1:0]      o_enemy_alive;
    logic                        o_player_iframe;
    logic                        o_ai_tick;
    logic [15:0]                 o_round_time;

    modport slave (
        input  i_select, i_pause, i_player_hit, i_player_shield,
               i_enemy_hit, i_enemy_shield,
        output o_state, o_is_gaming, o_player_hp, o_enemy_hp,
               o_enemy_alive, o_player_iframe, o_ai_tick, o_round_time
    );

    modport master (
        output i_select, i_pause, i_player_hit, i_player_shield,
               i_enemy_hit, i_enemy_shield,
        input  o_state, o_is_gaming, o_player_hp, o_enemy_hp,
               o_enemy_alive, o_player_iframe, o_ai_tick, o_round_time
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
//
// Purpose: game-flow controller for the arena game. Owns the
// START/PLAY/PAUSE/WIN/LOSE state, the player and per-enemy HP registers,
// their invulnerability (iframe) counters, the AI tick divider and the round
// timer. Supports several enemies, pause and an optional round timeout.
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   game_io  game_flow_ctrl_if.slave bundle (see the interface file)
// ---------------------------------------------------------------------------
module game_flow_ctrl #(
    parameter int NUM_ENEMIES   = 2,
    parameter int HP_W          = 3,
    parameter int PLAYER_HP     = 3,
    parameter int ENEMY_HP      = 3,
    parameter int IFRAME_CYC    = 32,
    parameter int TICK_DIV      = 128,
    parameter int TIMEOUT_TICKS = 0
) (
    input  logic             clk,
    input  logic             rst,
    game_flow_ctrl_if.slave  game_io
);

    localparam int IF_W  = $clog2(IFRAME_CYC + 1);
    localparam int DIV_W = $clog2(TICK_DIV);

    localparam logic [HP_W-1:0]  PLAYER_HP_INIT = HP_W'(PLAYER_HP);
    localparam logic [HP_W-1:0]  ENEMY_HP_INIT  = HP_W'(ENEMY_HP);
    localparam logic [IF_W-1:0]  IFRAME_LOAD    = IF_W'(IFRAME_CYC);
    localparam logic [DIV_W-1:0] DIV_LAST       = DIV_W'(TICK_DIV - 1);
    localparam logic [15:0]      TIMEOUT_LIMIT  = 16'(TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [HP_W-1:0]  player_hp_q, player_hp_d;
    logic [IF_W-1:0]  player_if_q, player_if_d;
    logic [HP_W-1:0]  enemy_hp_q [NUM_ENEMIES];
    logic [HP_W-1:0]  enemy_hp_d [NUM_ENEMIES];
    logic [IF_W-1:0]  enemy_if_q [NUM_ENEMIES];
    logic [IF_W-1:0]  enemy_if_d [NUM_ENEMIES];
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [15:0]      round_time_q, round_time_d;
    logic             sel_q;
    logic             pause_q;

    logic                        sel_rise;
    logic                        pause_rise;
    logic                        timeout_hit;
    logic [NUM_ENEMIES-1:0]      enemy_alive;
    logic [NUM_ENEMIES*HP_W-1:0] enemy_hp_flat;

    // Only the rising edge of the debounced select/pause levels acts, so a
    // held button cannot repeatedly toggle the state.
    assign sel_rise   = game_io.i_select & ~sel_q;
    assign pause_rise = game_io.i_pause & ~pause_q;

    // A zero TIMEOUT_TICKS disables the round timeout altogether.
    assign timeout_hit = (TIMEOUT_TICKS != 0) && (round_time_q >= TIMEOUT_LIMIT);

    // Flatten the enemy HP array for the renderer and derive the alive mask
    // straight from the registered HP values.
    always_comb begin
        enemy_hp_flat = '0;
        enemy_alive   = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            enemy_hp_flat[i*HP_W +: HP_W] = enemy_hp_q[i];
            enemy_alive[i]                = (enemy_hp_q[i] != '0);
        end
    end

    // Next-state and datapath logic. Everything holds by default, which is
    // exactly the PAUSE behaviour. Damage, iframe countdown and the tick
    // divider only run in PLAY. The round timer counts tick pulses and
    // saturates; it is only cleared when a new round starts so that WIN/LOSE
    // can keep showing the final time. Starting a round reloads every HP and
    // clears every counter on the same edge.
    always_comb begin
        state_d      = state_q;
        player_hp_d  = player_hp_q;
        player_if_d  = player_if_q;
        enemy_hp_d   = enemy_hp_q;
        enemy_if_d   = enemy_if_q;
        div_d        = div_q;
        tick_d       = 1'b0;
        round_time_d = round_time_q;

        if (tick_q && (round_time_q != 16'hFFFF)) begin
            round_time_d = round_time_q + 16'd1;
        end

        case (state_q)
            ST_START: begin
                div_d = '0;
                if (sel_rise) begin
                    state_d      = ST_PLAY;
                    player_hp_d  = PLAYER_HP_INIT;
                    player_if_d  = '0;
                    round_time_d = '0;
                    for (int i = 0; i < NUM_ENEMIES; i++) begin
                        enemy_hp_d[i] = ENEMY_HP_INIT;
                        enemy_if_d[i] = '0;
                    end
                end
            end

            ST_PLAY: begin
                if (player_hp_q == '0) begin
                    state_d = ST_LOSE;
                end else if (enemy_alive == '0) begin
                    state_d = ST_WIN;
                end else if (timeout_hit) begin
                    state_d = ST_LOSE;
                end else if (pause_rise) begin
                    state_d = ST_PAUSE;
                end

                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end

                if (player_if_q != '0) begin
                    player_if_d = player_if_q - IF_W'(1);
                end
                if (game_io.i_player_hit && !game_io.i_player_shield &&
                    (player_hp_q != '0) && (player_if_q == '0)) begin
                    player_hp_d = player_hp_q - HP_W'(1);
                    player_if_d = IFRAME_LOAD;
                end

                for (int i = 0; i < NUM_ENEMIES; i++) begin
                    if (enemy_if_q[i] != '0) begin
                        enemy_if_d[i] = enemy_if_q[i] - IF_W'(1);
                    end
                    if (game_io.i_enemy_hit[i] && !game_io.i_enemy_shield[i] &&
                        (enemy_hp_q[i] != '0) && (enemy_if_q[i] == '0)) begin
                        enemy_hp_d[i] = enemy_hp_q[i] - HP_W'(1);
                        enemy_if_d[i] = IFRAME_LOAD;
                    end
                end
            end

            ST_PAUSE: begin
                if (pause_rise) begin
                    state_d = ST_PLAY;
                end else if (sel_rise) begin
                    state_d = ST_START;
                end
            end

            ST_WIN, ST_LOSE: begin
                div_d = '0;
                if (sel_rise) begin
                    state_d = ST_START;
                end
            end

            default: begin
                state_d = ST_START;
                div_d   = '0;
            end
        endcase
    end

    // State and datapath registers. Reset puts the game back to the title
    // screen with full HP so the renderer has sane values immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_START;
            player_hp_q  <= PLAYER_HP_INIT;
            player_if_q  <= '0;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                enemy_hp_q[i] <= ENEMY_HP_INIT;
                enemy_if_q[i] <= '0;
            end
            div_q        <= '0;
            tick_q       <= 1'b0;
            round_time_q <= '0;
            sel_q        <= 1'b0;
            pause_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            player_hp_q  <= player_hp_d;
            player_if_q  <= player_if_d;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                enemy_hp_q[i] <= enemy_hp_d[i];
                enemy_if_q[i] <= enemy_if_d[i];
            end
            div_q        <= div_d;
            tick_q       <= tick_d;
            round_time_q <= round_time_d;
            sel_q        <= game_io.i_select;
            pause_q      <= game_io.i_pause;
        end
    end

    assign game_io.o_state         = state_q;
    assign game_io.o_is_gaming     = (state_q == ST_PLAY);
    assign game_io.o_player_hp     = player_hp_q;
    assign game_io.o_enemy_hp      = enemy_hp_flat;
    assign game_io.o_enemy_alive   = enemy_alive;
    assign game_io.o_player_iframe = (player_if_q != '0);
    assign game_io.o_ai_tick       = tick_q;
    assign game_io.o_round_time    = round_time_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_flow_ctrl
//
// Purpose: directed testbench for game_flow_ctrl. Instance A uses the default
// parameters (2 enemies, HP 3, 32 iframe cycles, 128-cycle AI tick, no
// timeout). Instance B uses an 8-cycle tick and a 4-tick round timeout.
// Inputs change 1 time unit after a rising clock edge; outputs are checked
// at that same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_game_flow_ctrl;

    logic clk = 1'b0;
    logic rstA;
    logic rstB;
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;

    // Free-running 10-unit clock shared by both instances.
    always #5 clk = ~clk;

    game_flow_ctrl_if #(.NUM_ENEMIES(2), .HP_W(3)) busA ();
    game_flow_ctrl_if #(.NUM_ENEMIES(2), .HP_W(3)) busB ();

    game_flow_ctrl dutA (
        .clk     (clk),
        .rst     (rstA),
        .game_io (busA)
    );

    game_flow_ctrl #(
        .TICK_DIV      (8),
        .TIMEOUT_TICKS (4)
    ) dutB (
        .clk     (clk),
        .rst     (rstB),
        .game_io (busB)
    );

    // Advance n rising edges and settle just after the last one.
    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive every input of instance A in one call.
    task automatic applyStimulus(input logic sel, input logic pause,
                                 input logic pHit, input logic pShield,
                                 input logic [1:0] eHit, input logic [1:0] eShield);
        busA.i_select        = sel;
        busA.i_pause         = pause;
        busA.i_player_hit    = pHit;
        busA.i_player_shield = pShield;
        busA.i_enemy_hit     = eHit;
        busA.i_enemy_shield  = eShield;
    endtask

    // One comparison: counts it, and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Directed sequence: reset, round start, player damage/iframes, AI tick,
    // enemy kills with shield, win, simultaneous lethal hits, pause, then the
    // timeout and mid-round reset on instance B.
    initial begin
        rstA = 1'b1;
        rstB = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        busB.i_select        = 1'b0;
        busB.i_pause         = 1'b0;
        busB.i_player_hit    = 1'b0;
        busB.i_player_shield = 1'b0;
        busB.i_enemy_hit     = 2'b00;
        busB.i_enemy_shield  = 2'b00;
        stepCycles(2);

        checkOutput("rst_state", busA.o_state, 0);
        checkOutput("rst_php", busA.o_player_hp, 3);
        checkOutput("rst_ehp", busA.o_enemy_hp, 27);
        checkOutput("rst_alive", busA.o_enemy_alive, 3);
        checkOutput("rst_tick", busA.o_ai_tick, 0);
        checkOutput("rst_round", busA.o_round_time, 0);
        checkOutput("rst_iframe", busA.o_player_iframe, 0);
        checkOutput("rst_gaming", busA.o_is_gaming, 0);

        rstA = 1'b0;
        rstB = 1'b0;
        stepCycles(1);
        $display("[TB] reset released");

        // Round start: PLAY one edge after the select rise.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("start_state", busA.o_state, 1);
        checkOutput("start_gaming", busA.o_is_gaming, 1);
        checkOutput("start_php", busA.o_player_hp, 3);
        checkOutput("start_ehp", busA.o_enemy_hp, 27);

        // PLAY cycle 0: damaging hit.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("hit0_php", busA.o_player_hp, 2);
        checkOutput("hit0_iframe", busA.o_player_iframe, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(9);

        // PLAY cycle 10: inside the iframe window, ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("hit10_php", busA.o_player_hp, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(21);
        checkOutput("iframe_c32", busA.o_player_iframe, 1);
        stepCycles(1);
        checkOutput("iframe_c33", busA.o_player_iframe, 0);
        stepCycles(7);

        // PLAY cycle 40: damaging again.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("hit40_php", busA.o_player_hp, 1);
        checkOutput("hit40_iframe", busA.o_player_iframe, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // First AI tick pulse lands in PLAY cycle 128.
        stepCycles(86);
        checkOutput("tick_c127", busA.o_ai_tick, 0);
        stepCycles(1);
        checkOutput("tick_c128", busA.o_ai_tick, 1);
        checkOutput("round_c128", busA.o_round_time, 0);
        stepCycles(1);
        checkOutput("tick_c129", busA.o_ai_tick, 0);
        checkOutput("round_c129", busA.o_round_time, 1);

        // Enemy kills; enemy 1 shielded on its first attempt.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b10);
        stepCycles(1);
        checkOutput("ehit1_ehp", busA.o_enemy_hp, 26);
        checkOutput("ehit1_alive", busA.o_enemy_alive, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(40);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
        stepCycles(1);
        checkOutput("ehit2_ehp", busA.o_enemy_hp, 17);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(40);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
        stepCycles(1);
        checkOutput("ehit3_ehp", busA.o_enemy_hp, 8);
        checkOutput("ehit3_alive", busA.o_enemy_alive, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(40);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        stepCycles(1);
        checkOutput("ehit4_ehp", busA.o_enemy_hp, 0);
        checkOutput("ehit4_alive", busA.o_enemy_alive, 0);
        checkOutput("ehit4_state", busA.o_state, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("win_state", busA.o_state, 3);
        checkOutput("win_gaming", busA.o_is_gaming, 0);
        stepCycles(5);
        checkOutput("win_php_held", busA.o_player_hp, 1);
        checkOutput("win_ehp_held", busA.o_enemy_hp, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("win_to_start", busA.o_state, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);

        // New round: simultaneous lethal hits on player and last enemy.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("r2_state", busA.o_state, 1);
        checkOutput("r2_php", busA.o_player_hp, 3);
        checkOutput("r2_ehp", busA.o_enemy_hp, 27);
        checkOutput("r2_round", busA.o_round_time, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00);
        stepCycles(1);
        checkOutput("r2_hitA_ehp", busA.o_enemy_hp, 18);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(40);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00);
        stepCycles(1);
        checkOutput("r2_hitB_php", busA.o_player_hp, 1);
        checkOutput("r2_hitB_ehp", busA.o_enemy_hp, 9);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(40);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        stepCycles(1);
        checkOutput("r2_hitC_ehp", busA.o_enemy_hp, 8);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(40);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00);
        stepCycles(1);
        checkOutput("lethal_php", busA.o_player_hp, 0);
        checkOutput("lethal_ehp", busA.o_enemy_hp, 0);
        checkOutput("lethal_state", busA.o_state, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("lose_state", busA.o_state, 4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("lose_to_start", busA.o_state, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);

        // Pause round: freeze, resume with the divider continuing.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(130);
        checkOutput("p_round_pre", busA.o_round_time, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("p_state", busA.o_state, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(500);
        checkOutput("p_state_500", busA.o_state, 2);
        checkOutput("p_round_500", busA.o_round_time, 1);
        checkOutput("p_tick_500", busA.o_ai_tick, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("resume_state", busA.o_state, 1);
        stepCycles(124);
        checkOutput("resume_tick_pre", busA.o_ai_tick, 0);
        stepCycles(1);
        checkOutput("resume_tick", busA.o_ai_tick, 1);
        stepCycles(1);
        checkOutput("resume_round", busA.o_round_time, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("p2_state", busA.o_state, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        stepCycles(1);
        checkOutput("pause_to_start", busA.o_state, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Instance B: timeout after 4 ticks of 8 cycles.
        busB.i_select = 1'b1;
        stepCycles(1);
        checkOutput("b_start_state", busB.o_state, 1);
        busB.i_select = 1'b0;
        stepCycles(32);
        checkOutput("b_tick_c32", busB.o_ai_tick, 1);
        checkOutput("b_round_c32", busB.o_round_time, 3);
        stepCycles(1);
        checkOutput("b_state_c33", busB.o_state, 1);
        checkOutput("b_round_c33", busB.o_round_time, 4);
        stepCycles(1);
        checkOutput("b_timeout_lose", busB.o_state, 4);

        // Instance B: mid-round asynchronous reset.
        busB.i_select = 1'b1;
        stepCycles(1);
        checkOutput("b_to_start", busB.o_state, 0);
        busB.i_select = 1'b0;
        stepCycles(1);
        busB.i_select = 1'b1;
        stepCycles(1);
        busB.i_select = 1'b0;
        busB.i_player_hit = 1'b1;
        stepCycles(1);
        checkOutput("b_hit_php", busB.o_player_hp, 2);
        busB.i_player_hit = 1'b0;
        stepCycles(3);
        #2;
        rstB = 1'b1;
        #1;
        checkOutput("b_arst_state", busB.o_state, 0);
        checkOutput("b_arst_php", busB.o_player_hp, 3);
        checkOutput("b_arst_iframe", busB.o_player_iframe, 0);
        stepCycles(1);
        rstB = 1'b0;
        stepCycles(1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
